// File: rtl/sprite_motion.sv
// Keyboard-driven sprite motion controller: per-frame position update with
// configurable bounds, step and edge behaviour, plus pause and homing states.
module sprite_motion #(
  parameter int W        = 10,
  parameter int X_MIN    = 0,
  parameter int X_MAX    = 639,
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 479,
  parameter int X_CENTER = 320,
  parameter int Y_CENTER = 240,
  parameter int SIZE     = 4,
  parameter int STEP     = 1,
  parameter int MODE     = 0
) (
  input  logic         frame_clk,
  input  logic         Reset_n,
  input  logic [7:0]   keycode,
  output logic [W-1:0] BallX,
  output logic [W-1:0] BallY,
  output logic [W-1:0] BallS,
  output logic         Hit_X,
  output logic         Hit_Y,
  output logic [1:0]   State
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_PAUSE = 2'b01,
    ST_HOME  = 2'b10
  } state_t;

  localparam logic [7:0] KEY_A     = 8'h04;
  localparam logic [7:0] KEY_D     = 8'h07;
  localparam logic [7:0] KEY_S     = 8'h16;
  localparam logic [7:0] KEY_W     = 8'h1A;
  localparam logic [7:0] KEY_SPACE = 8'h2C;
  localparam logic [7:0] KEY_H     = 8'h0B;

  localparam logic [W-1:0]        STEP_U = W'(STEP);
  localparam logic signed [W:0]   STEP_S = (W+1)'(STEP);
  localparam logic signed [W+1:0] LO_X   = (W+2)'(X_MIN + SIZE);
  localparam logic signed [W+1:0] HI_X   = (W+2)'(X_MAX - SIZE);
  localparam logic signed [W+1:0] LO_Y   = (W+2)'(Y_MIN + SIZE);
  localparam logic signed [W+1:0] HI_Y   = (W+2)'(Y_MAX - SIZE);
  localparam logic [W-1:0]        XC     = W'(X_CENTER);
  localparam logic [W-1:0]        YC     = W'(Y_CENTER);

  state_t              state_q, state_d;
  logic [W-1:0]        x_q, x_d, y_q, y_d;
  logic signed [W:0]   mx_q, mx_d, my_q, my_d;
  logic signed [W:0]   mx_dec, my_dec;
  logic                hx_q, hx_d, hy_q, hy_d;
  logic [7:0]          prev_q;
  logic                key_edge;

  // One axis of RUN motion: candidate in W+2 signed bits so it never wraps,
  // then saturate at the limit and either reflect or kill the motion.
  function automatic void axis_step(
    input  logic [W-1:0]        pos,
    input  logic signed [W:0]   m,
    input  logic signed [W+1:0] lo,
    input  logic signed [W+1:0] hi,
    output logic [W-1:0]        pos_n,
    output logic signed [W:0]   m_n,
    output logic                hit
  );
    logic signed [W+1:0] cand;
    logic signed [W:0]   mag;
    cand = $signed({2'b00, pos}) + $signed({m[W], m});
    mag  = m[W] ? -m : m;
    pos_n = cand[W-1:0];
    m_n   = m;
    hit   = 1'b0;
    if (cand > hi) begin
      pos_n = hi[W-1:0];
      hit   = 1'b1;
      m_n   = (MODE == 0) ? -mag : '0;
    end else if (cand < lo) begin
      pos_n = lo[W-1:0];
      hit   = 1'b1;
      m_n   = (MODE == 0) ? mag : '0;
    end
  endfunction

  function automatic logic [W-1:0] home_step(input logic [W-1:0] pos, input logic [W-1:0] ctr);
    logic [W-1:0] r;
    if (pos > ctr)      r = ((pos - ctr) > STEP_U) ? pos - STEP_U : ctr;
    else if (pos < ctr) r = ((ctr - pos) > STEP_U) ? pos + STEP_U : ctr;
    else                r = pos;
    return r;
  endfunction

  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_RUN;
      x_q     <= XC;
      y_q     <= YC;
      mx_q    <= '0;
      my_q    <= '0;
      hx_q    <= 1'b0;
      hy_q    <= 1'b0;
      prev_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      hx_q    <= hx_d;
      hy_q    <= hy_d;
      prev_q  <= keycode;
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    mx_d     = mx_q;
    my_d     = my_q;
    hx_d     = 1'b0;
    hy_d     = 1'b0;
    mx_dec   = mx_q;
    my_dec   = my_q;
    key_edge = (keycode != prev_q);

    case (keycode)
      KEY_A:   begin mx_dec = -STEP_S; my_dec = '0; end
      KEY_D:   begin mx_dec =  STEP_S; my_dec = '0; end
      KEY_S:   begin my_dec =  STEP_S; mx_dec = '0; end
      KEY_W:   begin my_dec = -STEP_S; mx_dec = '0; end
      default: begin end
    endcase

    case (state_q)
      ST_RUN: begin
        // The transition frame itself is still a RUN frame and moves the sprite.
        axis_step(x_q, mx_dec, LO_X, HI_X, x_d, mx_d, hx_d);
        axis_step(y_q, my_dec, LO_Y, HI_Y, y_d, my_d, hy_d);
        if (key_edge && keycode == KEY_SPACE)  state_d = ST_PAUSE;
        else if (key_edge && keycode == KEY_H) state_d = ST_HOME;
      end
      ST_PAUSE: begin
        if (key_edge && keycode == KEY_SPACE)  state_d = ST_RUN;
        else if (key_edge && keycode == KEY_H) state_d = ST_HOME;
      end
      ST_HOME: begin
        x_d = home_step(x_q, XC);
        y_d = home_step(y_q, YC);
        if (x_d == XC && y_d == YC) begin
          mx_d    = '0;
          my_d    = '0;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign BallX = x_q;
  assign BallY = y_q;
  assign BallS = W'(SIZE);
  assign Hit_X = hx_q;
  assign Hit_Y = hy_q;
  assign State = state_q;

endmodule

// File: tb/tb_sprite_motion.sv
// Directed bench for sprite_motion: default instance plus bounce, clamp and
// homing variants, each driven by its own keycode stream off a shared clock.
module tb_sprite_motion;

  logic       frame_clk = 1'b0;
  logic       Reset_n   = 1'b1;
  logic [7:0] kc_a = 8'h00, kc_b = 8'h00, kc_c = 8'h00;

  logic [9:0] x0, y0, s0, x3, y3, s3, x4, y4, s4, x6, y6, s6;
  logic       hx0, hy0, hx3, hy3, hx4, hy4, hx6, hy6;
  logic [1:0] st0, st3, st4, st6;

  int total = 0;
  int bad   = 0;

  always #5 frame_clk = ~frame_clk;

  sprite_motion u0 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(kc_a),
    .BallX(x0), .BallY(y0), .BallS(s0), .Hit_X(hx0), .Hit_Y(hy0), .State(st0)
  );

  sprite_motion #(.STEP(3), .MODE(0), .X_CENTER(628)) u3 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(kc_b),
    .BallX(x3), .BallY(y3), .BallS(s3), .Hit_X(hx3), .Hit_Y(hy3), .State(st3)
  );

  sprite_motion #(.STEP(3), .MODE(1), .X_CENTER(628)) u4 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(kc_b),
    .BallX(x4), .BallY(y4), .BallS(s4), .Hit_X(hx4), .Hit_Y(hy4), .State(st4)
  );

  sprite_motion #(.STEP(4), .MODE(1), .X_MAX(334)) u6 (
    .frame_clk(frame_clk), .Reset_n(Reset_n), .keycode(kc_c),
    .BallX(x6), .BallY(y6), .BallS(s6), .Hit_X(hx6), .Hit_Y(hy6), .State(st6)
  );

  task automatic check(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge frame_clk);
    #1;
  endtask

  initial begin
    // reset
    #2 Reset_n = 1'b0;
    #1;
    check("rst_x", x0, 320);
    check("rst_y", y0, 240);
    check("rst_state", st0, 0);
    check("rst_hit", {hx0, hy0}, 0);
    check("rst_size", s0, 4);
    check("rst_x_u3", x3, 628);
    #4 Reset_n = 1'b1;

    // single D press then coast
    kc_a = 8'h07; tick();
    check("d_first", x0, 321);
    kc_a = 8'h00;
    for (int i = 0; i < 5; i++) tick();
    check("coast_x", x0, 326);
    check("coast_y", y0, 240);

    // async reset mid-motion
    Reset_n = 1'b0; #2;
    check("mid_rst_x", x0, 320);
    check("mid_rst_state", st0, 0);
    Reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("idle_x", x0, 320);
    check("idle_y", y0, 240);

    // pause / resume
    kc_a = 8'h07; tick();
    check("pre_pause_x", x0, 321);
    kc_a = 8'h2C; tick();
    check("pause_state", st0, 1);
    check("pause_x0", x0, 322);
    tick(); tick();
    check("pause_frozen", x0, 322);
    check("pause_state_held", st0, 1);
    kc_a = 8'h04; tick();
    check("pause_dir_ignored", x0, 322);
    kc_a = 8'h00; tick();
    kc_a = 8'h2C; tick();
    check("resume_state", st0, 0);
    check("resume_x", x0, 322);
    tick();
    check("resume_move", x0, 323);
    kc_a = 8'h00; tick();
    check("resume_move2", x0, 324);

    // right edge: bounce (u3) versus clamp (u4)
    kc_b = 8'h07; tick();
    check("edge_x_u3", x3, 631);
    kc_b = 8'h00; tick();
    check("edge_x2_u3", x3, 634);
    tick();
    check("hit_x_u3", x3, 635);
    check("hit_flag_u3", hx3, 1);
    check("hit_x_u4", x4, 635);
    check("hit_flag_u4", hx4, 1);
    tick();
    check("bounce_x_u3", x3, 632);
    check("bounce_flag_u3", hx3, 0);
    check("clamp_x_u4", x4, 635);
    check("clamp_flag_u4", hx4, 0);
    tick();
    check("bounce_x2_u3", x3, 629);
    check("clamp_x2_u4", x4, 635);

    // top edge on the Y axis
    kc_b = 8'h1A; tick();
    check("w_y_u3", y3, 237);
    check("w_stops_x_u3", x3, 629);
    kc_b = 8'h00;
    for (int i = 0; i < 77; i++) tick();
    check("near_top_u3", y3, 6);
    tick();
    check("top_y_u3", y3, 4);
    check("top_hit_u3", hy3, 1);
    check("top_hit_x_u3", hx3, 0);
    tick();
    check("top_bounce_u3", y3, 7);
    check("top_hit_clear_u3", hy3, 0);
    check("top_clamp_u4", y4, 4);

    // homing with STEP=4 against a clamped right edge at 330
    kc_c = 8'h07; tick();
    check("h_x1", x6, 324);
    kc_c = 8'h00; tick();
    check("h_x2", x6, 328);
    tick();
    check("h_clamp", x6, 330);
    check("h_clamp_hit", hx6, 1);
    tick();
    check("h_stopped", x6, 330);
    kc_c = 8'h0B; tick();
    check("home_enter", st6, 2);
    check("home_x0", x6, 330);
    tick();
    check("home_x1", x6, 326);
    check("home_state1", st6, 2);
    tick();
    check("home_x2", x6, 322);
    tick();
    check("home_x3", x6, 320);
    check("home_done", st6, 0);
    kc_c = 8'h00; tick();
    check("home_motion_zero", x6, 320);
    check("home_y", y6, 240);

    // reset while homing
    kc_c = 8'h07; tick();
    kc_c = 8'h00; tick(); tick();
    check("h2_clamp", x6, 330);
    kc_c = 8'h0B; tick();
    check("h2_enter", st6, 2);
    tick();
    check("h2_step", x6, 326);
    Reset_n = 1'b0; #2;
    check("h2_rst_x", x6, 320);
    check("h2_rst_y", y6, 240);
    check("h2_rst_state", st6, 0);
    Reset_n = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
